// File: rtl/grid_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grid_cursor_ctrl
// Description : Central cursor controller for a ROWS x COLS LED grid.
//               Edge-triggered moves with hold-to-repeat, cursor blink and a
//               one-cycle cell-toggle request on select.
//               Optional macro GRID_CURSOR_WRAP_EN: toroidal wrap at the edges
//               (default: saturate at the edges).
// Revision    : 1.0 - initial release
// ============================================================================
module grid_cursor_ctrl #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int BLINK_PERIOD  = 25_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4:0]                    key,
  input  logic                          run,
  output logic [$clog2(ROWS)-1:0]       row,
  output logic [$clog2(COLS)-1:0]       col,
  output logic [ROWS*COLS-1:0]          cursor_mask,
  output logic                          toggle_req,
  output logic [$clog2(ROWS*COLS)-1:0]  toggle_idx
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int CELLS   = ROWS * COLS;
  localparam int IDX_W   = $clog2(CELLS);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam int BLK_W   = $clog2(BLINK_PERIOD);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  logic [4:0]       r_key_q;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic [RPT_W-1:0] w_rpt_cnt_nxt;
  logic [1:0]       r_dir;
  logic [1:0]       w_dir;
  logic             w_dir_any;
  logic [3:0]       w_dir_keys;
  logic [3:0]       w_dir_keys_q;
  logic             w_dir_edge;
  logic             w_dir_same;
  logic             w_sel_edge;
  logic             w_move;
  logic [BLK_W-1:0] r_blink_cnt;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_toggle_req;
  logic [IDX_W-1:0] r_toggle_idx;
  logic [IDX_W-1:0] w_idx;

  assign w_dir_keys   = key[3:0];
  assign w_dir_keys_q = r_key_q[3:0];

  // Resolve the winning direction (up > down > left > right) and its edges
  always_comb begin
    w_dir_any = |w_dir_keys;
    w_dir     = D_RIGHT;
    if (w_dir_keys[0])      w_dir = D_UP;
    else if (w_dir_keys[1]) w_dir = D_DOWN;
    else if (w_dir_keys[2]) w_dir = D_LEFT;
    w_dir_edge = w_dir_any & ~run & w_dir_keys[w_dir] & ~w_dir_keys_q[w_dir];
    w_dir_same = w_dir_any & ~run & (w_dir == r_dir);
    w_sel_edge = key[4] & ~r_key_q[4] & ~run;
  end

  // Repeat FSM state register; the key history always tracks the keys
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rpt_cnt <= '0;
      r_dir     <= D_UP;
      r_key_q   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
      r_key_q   <= key;
      if (w_dir_edge) r_dir <= w_dir;
    end
  end

  // Repeat FSM next state: a fresh edge restarts the delay, anything else but
  // the same held direction drops back to idle
  always_comb begin
    w_state_nxt = r_state;
    if (run || !w_dir_any)                    w_state_nxt = S_IDLE;
    else if (w_dir_edge)                      w_state_nxt = S_DELAY;
    else if (r_state == S_IDLE || !w_dir_same) w_state_nxt = S_IDLE;
    else if (r_rpt_cnt == '0)                 w_state_nxt = S_REPEAT;
  end

  // Repeat FSM outputs: move strobe and counter reload/decrement
  always_comb begin
    w_move        = 1'b0;
    w_rpt_cnt_nxt = '0;
    if (w_dir_edge) begin
      w_move        = 1'b1;
      w_rpt_cnt_nxt = RPT_W'(REPEAT_DELAY - 1);
    end else if (r_state != S_IDLE && w_dir_same) begin
      if (r_rpt_cnt == '0) begin
        w_move        = 1'b1;
        w_rpt_cnt_nxt = RPT_W'(REPEAT_PERIOD - 1);
      end else begin
        w_rpt_cnt_nxt = r_rpt_cnt - RPT_W'(1);
      end
    end
  end

  // Cursor position update; edge behaviour selected by the wrap macro
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row <= ROW_W'(ROWS / 2);
      r_col <= COL_W'(COLS / 2);
    end else if (w_move) begin
      case (w_dir)
        D_UP: begin
          if (r_row != '0) r_row <= r_row - ROW_W'(1);
`ifdef GRID_CURSOR_WRAP_EN
          else             r_row <= ROW_W'(ROWS - 1);
`endif
        end
        D_DOWN: begin
          if (r_row != ROW_W'(ROWS - 1)) r_row <= r_row + ROW_W'(1);
`ifdef GRID_CURSOR_WRAP_EN
          else                           r_row <= '0;
`endif
        end
        D_LEFT: begin
          if (r_col != '0) r_col <= r_col - COL_W'(1);
`ifdef GRID_CURSOR_WRAP_EN
          else             r_col <= COL_W'(COLS - 1);
`endif
        end
        default: begin
          if (r_col != COL_W'(COLS - 1)) r_col <= r_col + COL_W'(1);
`ifdef GRID_CURSOR_WRAP_EN
          else                           r_col <= '0;
`endif
        end
      endcase
    end
  end

  // Blink counter; any move or select restarts it so the cursor shows at once
  always_ff @(posedge clk) begin
    if (reset)                                    r_blink_cnt <= '0;
    else if (w_move || w_sel_edge)                r_blink_cnt <= '0;
    else if (r_blink_cnt == BLK_W'(BLINK_PERIOD - 1)) r_blink_cnt <= '0;
    else                                          r_blink_cnt <= r_blink_cnt + BLK_W'(1);
  end

  // Select pulse; index captured from the pre-move position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle_req <= 1'b0;
      r_toggle_idx <= '0;
    end else begin
      r_toggle_req <= w_sel_edge;
      if (w_sel_edge) r_toggle_idx <= w_idx;
    end
  end

  assign w_idx       = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(r_col);
  assign row         = r_row;
  assign col         = r_col;
  assign toggle_req  = r_toggle_req;
  assign toggle_idx  = r_toggle_idx;
  assign cursor_mask = (!run && (r_blink_cnt < BLK_W'(BLINK_PERIOD / 2)))
                       ? ({{(CELLS-1){1'b0}}, 1'b1} << w_idx) : '0;

endmodule
`default_nettype wire

// File: tb/tb_grid_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_cursor_ctrl
// Description : Scoreboard bench for grid_cursor_ctrl with a behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_cursor_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RD   = 4;
  localparam int RP   = 2;
  localparam int BP   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  key = '0;
  logic        run = 1'b0;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [63:0] cursor_mask;
  logic        toggle_req;
  logic [5:0]  toggle_idx;

  grid_cursor_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .BLINK_PERIOD(BP)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .run(run),
    .row(row), .col(col), .cursor_mask(cursor_mask),
    .toggle_req(toggle_req), .toggle_idx(toggle_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    logic [63:0] mask;
    logic        tog;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: position, cycles since last move/select (age),
  // tracked held direction (-1 = none) and cycles held since its edge move
  int         m_row, m_col, m_age, m_held, m_hold, m_idx;
  logic [4:0] m_kp;

  task automatic model_step(input logic [4:0] k, input logic r, input logic rs);
    exp_t e;
    int   dir;
    bit   mv;
    bit   sel;
    if (rs) begin
      m_row = ROWS / 2; m_col = COLS / 2; m_age = 0;
      m_held = -1; m_hold = 0; m_idx = 0; m_kp = '0;
      e.tog = 1'b0;
    end else begin
      dir = -1;
      for (int i = 3; i >= 0; i--) if (k[i]) dir = i;
      mv = 0;
      if (r || dir < 0) m_held = -1;
      else if (k[dir] && !m_kp[dir]) begin
        mv = 1; m_held = dir; m_hold = 0;
      end else if (m_held == dir) begin
        m_hold++;
        if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0)) mv = 1;
      end else m_held = -1;
      sel = k[4] && !m_kp[4] && !r;
      if (sel) m_idx = m_row * COLS + m_col;
      e.tog = sel;
      if (mv) begin
`ifdef GRID_CURSOR_WRAP_EN
        case (dir)
          0: m_row = (m_row + ROWS - 1) % ROWS;
          1: m_row = (m_row + 1) % ROWS;
          2: m_col = (m_col + COLS - 1) % COLS;
          default: m_col = (m_col + 1) % COLS;
        endcase
`else
        case (dir)
          0: m_row = (m_row > 0) ? m_row - 1 : 0;
          1: m_row = (m_row < ROWS - 1) ? m_row + 1 : ROWS - 1;
          2: m_col = (m_col > 0) ? m_col - 1 : 0;
          default: m_col = (m_col < COLS - 1) ? m_col + 1 : COLS - 1;
        endcase
`endif
      end
      m_age = (mv || sel) ? 0 : m_age + 1;
      m_kp  = k;
    end
    e.row  = m_row;
    e.col  = m_col;
    e.idx  = m_idx;
    e.mask = (!r && (m_age % BP) < BP / 2) ? (64'd1 << (m_row * COLS + m_col)) : 64'd0;
    q.push_back(e);
  endtask

  task automatic step(input logic [4:0] k, input logic r, input logic rs);
    @(negedge clk);
    key   = k;
    run   = r;
    reset = rs;
    model_step(k, r, rs);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected snapshot per clock and compares the outputs
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("row",         {61'd0, row},        64'(mon_e.row));
        chk("col",         {61'd0, col},        64'(mon_e.col));
        chk("cursor_mask", cursor_mask,         mon_e.mask);
        chk("toggle_req",  {63'd0, toggle_req}, {63'd0, mon_e.tog});
        chk("toggle_idx",  {58'd0, toggle_idx}, 64'(mon_e.idx));
      end
    end
  end

  logic [4:0] rk;
  logic       rr;
  int         guard;

  initial begin
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);
    // single right pulse, then right held shorter than the repeat delay
    step(5'b01000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    repeat (3) step(5'b01000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    // back to centre, hold down long enough to repeat into the bottom edge
    step(5'b00000, 1'b0, 1'b1);
    repeat (16) step(5'b00010, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    // up and left together from the centre: only up applies
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00101, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    // walk to (2,6) and select with the key held
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    step(5'b01000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    step(5'b01000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    repeat (4) step(5'b10000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    // select and move edges together
    step(5'b10010, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    // keys pressed while running, still held after run drops
    repeat (3) step(5'b11001, 1'b1, 1'b0);
    repeat (6) step(5'b11001, 1'b0, 1'b0);
    repeat (12) step(5'b00000, 1'b0, 1'b0);
    // randomized phase
    rk = '0;
    rr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)  rk = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) rr = ~rr;
      step(rk, rr, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    step(5'b00000, 1'b0, 1'b0);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #5;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grid_cursor_ctrl.md
# grid_cursor_ctrl

Centralised cursor controller for the Life LED grid. It replaces the per-cell cursor flops with one registered (row, col) position. The block handles edge-detected moves with hold-to-repeat, blinks the cursor, and issues a one-cycle cell-toggle request on select. It sits between the debounced key inputs and the grid/display logic, and generalises cursor motion to any ROWS × COLS grid.

## Interface
- ROWS, 8: grid rows, ≥2
- COLS, 8: grid columns, ≥2
- REPEAT_DELAY, 25_000_000: cycles a direction is held before the first auto-repeat, ≥2
- REPEAT_PERIOD, 5_000_000: cycles between later auto-repeats, ≥2
- BLINK_PERIOD, 25_000_000: full blink cycle in cycles, even, ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- key  in  5  active-high, already debounced and synchronised; [0] up, [1] down, [2] left, [3] right, [4] select
- run  in  1  1 = simulation running: cursor hidden, keys ignored
- row  out  $clog2(ROWS)  cursor row
- col  out  $clog2(COLS)  cursor column
- cursor_mask  out  ROWS*COLS  one-hot at bit row*COLS+col while visible, else 0
- toggle_req  out  1  one-cycle pulse requesting toggle of the cell at toggle_idx
- toggle_idx  out  $clog2(ROWS*COLS)  linear index row*COLS+col, captured with toggle_req

## Operation
- Reset values:
  - row = ROWS/2, col = COLS/2
  - toggle_req = 0, toggle_idx = 0
  - blink counter = 0, so the cursor is visible
  - repeat counter = 0
  - key history = 0
- Direction resolution: among pressed direction keys, priority up > down > left > right; the winner is dir_sel. At most one move per cycle.
- Move trigger:
  - Fires on the rising edge of the dir_sel key (key & ~key_q).
  - Also fires on an auto-repeat tick.
- Moves:
  - up decrements row; down increments row.
  - left decrements col; right increments col.
- Repeat FSM, states IDLE, DELAY and REPEAT:
  - IDLE → DELAY on a move trigger; the counter is loaded with REPEAT_DELAY-1.
  - DELAY → REPEAT when the counter reaches 0 with the same dir_sel still held. This issues a move and reloads REPEAT_PERIOD-1.
  - REPEAT stays in REPEAT, issuing a move and reloading each time the counter reaches 0.
  - Any state → IDLE if dir_sel is released or changes, or if run=1. A changed direction that is newly pressed triggers its own edge move that same cycle and enters DELAY.
- Select: a rising edge on key[4] with run=0 pulses toggle_req for one cycle with toggle_idx = the current position. It is independent of direction moves. If a move occurs in the same cycle, toggle_idx uses the pre-move position.
- Blink:
  - The counter wraps at BLINK_PERIOD-1.
  - Visible while the counter < BLINK_PERIOD/2.
  - Any move or select clears the counter, so the cursor is shown immediately.
- run=1:
  - cursor_mask = 0.
  - Moves and select are suppressed; the repeat FSM is held in IDLE.
  - row/col are retained.
  - Key history still updates, so keys held across run 1→0 do not fire.

## Timing
- A key rising at cycle N (sampled at edge N) updates row/col at edge N+1. The new cursor_mask is visible from N+1.
- toggle_req is high for exactly cycle N+1.
- First repeat comes REPEAT_DELAY cycles after the edge move; later repeats come every REPEAT_PERIOD cycles.
- Reset asserted mid-repeat or mid-blink returns every register to its reset value at the next edge.
- Edge conditions are evaluated without regard to held state: simultaneous select-edge and direction-edge both act in the same cycle.

## Configuration
- GRID_CURSOR_WRAP_EN defined: moves wrap toroidally.
  - Row 0 up → ROWS-1; row ROWS-1 down → 0.
  - Col 0 left → COLS-1; col COLS-1 right → 0.
  - Matches the toroidal Life grid.
- Undefined: moves saturate at the edges. A move at an edge leaves the position unchanged but still clears the blink counter and still counts as a repeat tick.

## Test plan
- Reset with ROWS=COLS=8 → row=4, col=4, cursor_mask bit 36 set, toggle_req=0.
- Pulse key[3] for one cycle from (4,4) → col=5 at N+1, mask bit 37; no further move with the key held for under REPEAT_DELAY cycles.
- Hold key[1] with REPEAT_DELAY=4 and REPEAT_PERIOD=2 → row 4→5 at edge+1, then 6 four cycles later, then 7 two cycles after that. Then:
  - GRID_CURSOR_WRAP_EN defined → row 0.
  - Undefined → row stays at 7.
- Press key[0] and key[2] in the same cycle from (4,4) → only up applies: (3,4).
- Press key[4] at (2,6) → one-cycle toggle_req, toggle_idx=22. Keep the key held → no second pulse.
- Assert run=1, press keys, then deassert with keys still held → mask=0 while running, position unchanged, no move or toggle after the release of run.
